// File: rtl/mul32_pkg.sv
// Shared constants for the sequential 32x32 multiplier.
package mul32_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration count and counter width
    localparam int MUL_STEPS = 32;
    localparam int MUL_CNT_W = 5;

    // Count value on which the final shift-and-add step happens
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_STEPS - 1);

endpackage

// File: rtl/add32.sv
// 32-bit ripple adder with carry-in, carry-out and signed overflow flag.
module add32 (
    input  logic [31:0] in_data0,
    input  logic [31:0] in_data1,
    input  logic        in_carry,
    output logic [31:0] out_sum,
    output logic        out_carry,
    output logic        out_overflow
);

    logic [32:0] full_sum;

    // 33-bit sum; overflow is set when like-signed operands give an unlike-signed sum
    always_comb begin
        full_sum     = {1'b0, in_data0} + {1'b0, in_data1} + {32'd0, in_carry};
        out_sum      = full_sum[31:0];
        out_carry    = full_sum[32];
        out_overflow = (in_data0[31] == in_data1[31]) && (full_sum[31] != in_data0[31]);
    end

endmodule

// File: rtl/mul32_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier sharing one add32.
module mul32_seq
    import mul32_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_reset,
    input  logic        in_start,
    input  logic [31:0] in_data0,
    input  logic [31:0] in_data1,
    input  logic        in_ack,
    output logic        out_ready,
    output logic        out_busy,
    output logic        out_valid,
    output logic [31:0] out_lo,
    output logic [31:0] out_hi
);

    logic [1:0]           state_q, state_d;
    logic [31:0]          mcand_q, mcand_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        carry;
    logic        ovf_unused;

    // Partial-product selection: add the multiplicand only when the current multiplier bit is set
    always_comb begin
        addend = lo_q[0] ? mcand_q : 32'd0;
    end

    add32 u_add32 (
        .in_data0     (hi_q),
        .in_data1     (addend),
        .in_carry     (1'b0),
        .out_sum      (sum),
        .out_carry    (carry),
        .out_overflow (ovf_unused)
    );

    // Next-state and datapath update: accept in IDLE, one shift-add step per RUN cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    mcand_d = in_data0;
                    lo_d    = in_data1;
                    hi_d    = 32'd0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // {carry, sum, lo} shifted right by one; the consumed multiplier bit drops out
                hi_d  = {carry, sum[31:1]};
                lo_d  = {sum[0], lo_q[31:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MUL_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start in the same cycle as the ack is deliberately dropped
                if (in_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure state decodes or direct register taps
    always_comb begin
        out_ready = (state_q == ST_IDLE);
        out_busy  = (state_q == ST_RUN);
        out_valid = (state_q == ST_DONE);
        out_hi    = hi_q;
        out_lo    = lo_q;
    end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed-vector bench for mul32_seq.
module tb_mul32_seq;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b0;
    logic        in_start = 1'b0;
    logic [31:0] in_data0 = 32'd0;
    logic [31:0] in_data1 = 32'd0;
    logic        in_ack = 1'b0;
    logic        out_ready;
    logic        out_busy;
    logic        out_valid;
    logic [31:0] out_lo;
    logic [31:0] out_hi;

    int n_checks = 0;
    int n_pass   = 0;

    mul32_seq dut (
        .in_clk    (in_clk),
        .in_reset  (in_reset),
        .in_start  (in_start),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ack    (in_ack),
        .out_ready (out_ready),
        .out_busy  (out_busy),
        .out_valid (out_valid),
        .out_lo    (out_lo),
        .out_hi    (out_hi)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Present operands and hold start for exactly one edge (the accept edge)
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!out_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_data0 = a;
        in_data1 = b;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded)
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_ack();
        in_ack = 1'b1;
        tick();
        in_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] held;
        logic        stable;

        // Reset for two cycles
        in_reset = 1'b1;
        tick();
        tick();
        in_reset = 1'b0;
        chk("rst_ready", {63'd0, out_ready}, 64'd1);
        chk("rst_busy",  {63'd0, out_busy},  64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_prod",  {out_hi, out_lo},   64'd0);

        // Simple product 3 x 5; valid appears after edge N+32
        start_op(32'd3, 32'd5);
        chk("simple_busy", {63'd0, out_busy}, 64'd1);
        wait_valid(lat);
        chk("simple_lat",  64'(lat), 64'd32);
        chk("simple_prod", {out_hi, out_lo}, 64'h0000_0000_0000_000F);
        do_ack();
        chk("simple_ack_ready", {63'd0, out_ready}, 64'd1);

        // Maximum operands exercise the carry-out path
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat);
        chk("max_lat",  64'(lat), 64'd32);
        chk("max_prod", {out_hi, out_lo}, 64'hFFFF_FFFE_0000_0001);
        do_ack();

        // Zero multiplicand, with a 7 x 7 start during RUN that must be ignored
        start_op(32'h0000_0000, 32'hDEAD_BEEF);
        repeat (5) tick();
        in_data0 = 32'd7;
        in_data1 = 32'd7;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("zero_busy_after_start", {63'd0, out_busy}, 64'd1);
        wait_valid(lat);
        chk("zero_lat",  64'(lat), 64'd26);
        chk("zero_prod", {out_hi, out_lo}, 64'd0);
        do_ack();
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid || out_busy) seen++;
        end
        chk("zero_no_second", 64'(seen), 64'd0);

        // Delayed ack: hold DONE for 10 cycles
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_valid(lat);
        chk("dly_prod", {out_hi, out_lo}, 64'h0000_0001_0000_0000);
        held = {out_hi, out_lo};
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!out_valid || ({out_hi, out_lo} !== held)) stable = 1'b0;
        end
        chk("dly_hold", {63'd0, stable}, 64'd1);
        do_ack();
        chk("dly_ready", {63'd0, out_ready}, 64'd1);
        // Restart at the very next edge
        in_data0 = 32'hFFFF_FFFF;
        in_data1 = 32'd2;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("b2b_busy", {63'd0, out_busy}, 64'd1);
        wait_valid(lat);
        chk("b2b_lat",  64'(lat), 64'd32);
        chk("b2b_prod", {out_hi, out_lo}, 64'h0000_0001_FFFF_FFFE);
        do_ack();

        // Reset in the middle of a run
        start_op(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (15) tick();
        chk("mid_busy", {63'd0, out_busy}, 64'd1);
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        chk("mid_rst_ready", {63'd0, out_ready}, 64'd1);
        chk("mid_rst_busy",  {63'd0, out_busy},  64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_prod",  {out_hi, out_lo},   64'd0);
        start_op(32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid(lat);
        chk("fresh_lat",  64'(lat), 64'd32);
        chk("fresh_prod", {out_hi, out_lo}, 64'h0B00_EA4E_242D_2080);

        // Start and ack together in DONE: ack wins, no accept
        in_data0 = 32'd9;
        in_data1 = 32'd9;
        in_start = 1'b1;
        in_ack   = 1'b1;
        tick();
        in_start = 1'b0;
        in_ack   = 1'b0;
        chk("both_ready", {63'd0, out_ready}, 64'd1);
        chk("both_busy",  {63'd0, out_busy},  64'd0);
        chk("both_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("both_busy_later", {63'd0, out_busy}, 64'd0);
        chk("both_prod_kept",  {out_hi, out_lo}, 64'h0B00_EA4E_242D_2080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
